// File: rtl/gps_track_feeder.sv
// gps_track_feeder: walks a track's points into a distance calculator and accumulates the returned segment lengths.
module gps_track_feeder #(
   parameter int FIRST_GAP = 255,
   parameter int TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [6:0]  N_PTS,
   output logic [5:0]  PT_ADDR,
   input  logic [47:0] PT_DATA,
   output logic        DEN,
   output logic [23:0] LON_OUT,
   output logic [23:0] LAT_OUT,
   input  logic        Valid,
   input  logic [39:0] D,
   output logic [47:0] TOTAL,
   output logic [5:0]  SEG_CNT,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam int CW = $clog2((FIRST_GAP > TIMEOUT ? FIRST_GAP : TIMEOUT) + 1);
   typedef enum logic [2:0] {IDLE, FETCH, SEND, GAP, WAIT, DONE, ERR} state_t;
   state_t        r_state, w_next;
   logic [6:0]    r_n;
   logic [CW-1:0] r_cnt;
   logic [5:0]    r_addr;
   logic [23:0]   r_lon, r_lat;
   logic [47:0]   r_total;
   logic [5:0]    r_seg;
   logic          r_err;
   logic [48:0]   w_sum;
   logic          w_gap_end, w_timeout, w_last;
   always_comb begin
      w_sum     = {1'b0, r_total} + {9'd0, D};
      w_gap_end = r_cnt == CW'(FIRST_GAP - 1);
      w_timeout = r_cnt == CW'(TIMEOUT - 1);
      w_last    = {1'b0, r_addr} == r_n - 7'd1;
      w_next    = r_state;
      case (r_state)
         IDLE:    if (start) w_next = N_PTS >= 7'd2 ? FETCH : DONE;
         FETCH:   w_next = SEND;
         SEND:    w_next = r_addr == 6'd0 ? GAP : WAIT;
         GAP:     if (w_gap_end) w_next = FETCH;
         WAIT:    if (Valid) w_next = w_last ? DONE : FETCH;
                  else if (w_timeout) w_next = ERR;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   // r_addr doubles as the point index; the counter restarts on every state change
   always_ff @(posedge clk)
      if (reset) begin
         r_n     <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_lon   <= '0;
         r_lat   <= '0;
         r_total <= '0;
         r_seg   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_cnt <= w_next == r_state ? r_cnt + CW'(1) : '0;
         case (r_state)
            IDLE: if (start) begin
               r_n     <= N_PTS;
               r_addr  <= '0;
               r_total <= '0;
               r_seg   <= '0;
               r_err   <= 1'b0;
            end
            FETCH: begin
               r_lon <= PT_DATA[47:24];
               r_lat <= PT_DATA[23:0];
            end
            GAP: if (w_gap_end) r_addr <= r_addr + 6'd1;
            WAIT: if (Valid) begin
               r_total <= w_sum[48] ? '1 : w_sum[47:0];
               r_seg   <= r_seg + 6'd1;
               if (!w_last) r_addr <= r_addr + 6'd1;
            end else if (w_timeout) r_err <= 1'b1;
            default: ;
         endcase
      end
   assign PT_ADDR = r_addr;
   assign LON_OUT = r_lon;
   assign LAT_OUT = r_lat;
   assign TOTAL   = r_total;
   assign SEG_CNT = r_seg;
   assign err     = r_err;
   assign DEN     = r_state == SEND;
   assign busy    = r_state != IDLE;
   assign done    = r_state == DONE || r_state == ERR;
endmodule
